// File: rtl/riscv_multi_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_multi_ctrl
// Main control unit for the multicycle RV32I core. A Moore FSM sequences one
// instruction at a time. Alongside it sit an ALU decoder, an immediate-source
// decoder and the branch-resolve logic.
//
// Ports:
//   i_clk, i_rst        clock; synchronous active-high reset
//   i_opcode, i_funct3  fields of the latched instruction register
//   i_funct7b5          instr[30]
//   i_zero              ALU zero flag, used for branch resolution
//   o_pc_en             PC enable (PC update, or a taken branch)
//   o_ir_en             instruction register / OldPC enable
//   o_mem_we, o_rf_we   memory and register file write strobes
//   o_adr_src           memory address select (0 PC, 1 Result)
//   o_result_src        result select (00 ALUOut, 01 Data, 10 ALUResult)
//   o_alu_src_a/b       ALU operand selects
//   o_imm_src           immediate type (00 I, 01 S, 10 B, 11 J)
//   o_alu_ctrl          ALU operation code
//   o_valid             one-cycle pulse per retired instruction
//   o_illegal           one-cycle pulse on an unsupported instruction
// -----------------------------------------------------------------------------
module riscv_multi_ctrl #(
   parameter int unsigned BW_CTRL = 4,
   parameter int unsigned BW_OP   = 7
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [BW_OP-1:0]   i_opcode,
   input  logic [2:0]         i_funct3,
   input  logic               i_funct7b5,
   input  logic               i_zero,
   output logic               o_pc_en,
   output logic               o_ir_en,
   output logic               o_mem_we,
   output logic               o_rf_we,
   output logic               o_adr_src,
   output logic [1:0]         o_result_src,
   output logic [1:0]         o_alu_src_a,
   output logic [1:0]         o_alu_src_b,
   output logic [1:0]         o_imm_src,
   output logic [BW_CTRL-1:0] o_alu_ctrl,
   output logic               o_valid,
   output logic               o_illegal
);

   localparam logic [BW_OP-1:0] OP_LW  = BW_OP'(7'b0000011);
   localparam logic [BW_OP-1:0] OP_SW  = BW_OP'(7'b0100011);
   localparam logic [BW_OP-1:0] OP_R   = BW_OP'(7'b0110011);
   localparam logic [BW_OP-1:0] OP_I   = BW_OP'(7'b0010011);
   localparam logic [BW_OP-1:0] OP_BR  = BW_OP'(7'b1100011);
   localparam logic [BW_OP-1:0] OP_JAL = BW_OP'(7'b1101111);

   localparam logic [BW_CTRL-1:0] ALU_ADD  = BW_CTRL'(4'b0000);
   localparam logic [BW_CTRL-1:0] ALU_SUB  = BW_CTRL'(4'b0001);
   localparam logic [BW_CTRL-1:0] ALU_AND  = BW_CTRL'(4'b0010);
   localparam logic [BW_CTRL-1:0] ALU_OR   = BW_CTRL'(4'b0011);
   localparam logic [BW_CTRL-1:0] ALU_XOR  = BW_CTRL'(4'b0100);
   localparam logic [BW_CTRL-1:0] ALU_SLT  = BW_CTRL'(4'b0101);
   localparam logic [BW_CTRL-1:0] ALU_SLL  = BW_CTRL'(4'b0110);
   localparam logic [BW_CTRL-1:0] ALU_SRL  = BW_CTRL'(4'b0111);
   localparam logic [BW_CTRL-1:0] ALU_SRA  = BW_CTRL'(4'b1000);
   localparam logic [BW_CTRL-1:0] ALU_SLTU = BW_CTRL'(4'b1001);

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAdr,
      StMemRead,
      StMemWrite,
      StMemWb,
      StExecR,
      StExecI,
      StAluWb,
      StBranch,
      StJal
   } state_t;

   typedef enum logic [1:0] {
      AluopAdd,
      AluopSub,
      AluopFunct
   } aluop_t;

   state_t state_q, state_d;

   logic              pc_update, branch, taken, dec_illegal;
   logic              ir_en, mem_we, rf_we, adr_src, valid, illegal;
   logic [1:0]        result_src, src_a, src_b, imm_src;
   aluop_t            aluop;
   logic [BW_CTRL-1:0] alu_ctrl;

   // Only beq/bne are supported; other branch funct3 values are rejected.
   always_comb begin
      dec_illegal = 1'b0;
      if (i_opcode == OP_BR) begin
         dec_illegal = (i_funct3[2:1] != 2'b00);
      end else if (i_opcode != OP_LW && i_opcode != OP_SW && i_opcode != OP_R &&
                   i_opcode != OP_I && i_opcode != OP_JAL) begin
         dec_illegal = 1'b1;
      end
   end

   always_comb begin
      state_d = StFetch;
      unique case (state_q)
         StFetch:  state_d = StDecode;
         StDecode: begin
            if (dec_illegal) begin
               state_d = StFetch;
            end else if (i_opcode == OP_LW || i_opcode == OP_SW) begin
               state_d = StMemAdr;
            end else if (i_opcode == OP_R) begin
               state_d = StExecR;
            end else if (i_opcode == OP_I) begin
               state_d = StExecI;
            end else if (i_opcode == OP_BR) begin
               state_d = StBranch;
            end else begin
               state_d = StJal;
            end
         end
         StMemAdr:   state_d = (i_opcode == OP_SW) ? StMemWrite : StMemRead;
         StMemRead:  state_d = StMemWb;
         StExecR:    state_d = StAluWb;
         StExecI:    state_d = StAluWb;
         StJal:      state_d = StAluWb;
         StMemWb:    state_d = StFetch;
         StMemWrite: state_d = StFetch;
         StAluWb:    state_d = StFetch;
         StBranch:   state_d = StFetch;
         default:    state_d = StFetch;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   // Moore decode of the state register.
   always_comb begin
      pc_update  = 1'b0;
      branch     = 1'b0;
      ir_en      = 1'b0;
      mem_we     = 1'b0;
      rf_we      = 1'b0;
      adr_src    = 1'b0;
      valid      = 1'b0;
      illegal    = 1'b0;
      result_src = 2'b00;
      src_a      = 2'b00;
      src_b      = 2'b00;
      aluop      = AluopAdd;
      unique case (state_q)
         StFetch: begin
            ir_en      = 1'b1;
            src_b      = 2'b10;
            result_src = 2'b10;
            pc_update  = 1'b1;
         end
         StDecode: begin
            src_a   = 2'b01;
            src_b   = 2'b01;
            illegal = dec_illegal;
         end
         StMemAdr: begin
            src_a = 2'b10;
            src_b = 2'b01;
         end
         StMemRead: adr_src = 1'b1;
         StMemWrite: begin
            adr_src = 1'b1;
            mem_we  = 1'b1;
            valid   = 1'b1;
         end
         StMemWb: begin
            result_src = 2'b01;
            rf_we      = 1'b1;
            valid      = 1'b1;
         end
         StExecR: begin
            src_a = 2'b10;
            aluop = AluopFunct;
         end
         StExecI: begin
            src_a = 2'b10;
            src_b = 2'b01;
            aluop = AluopFunct;
         end
         StAluWb: begin
            rf_we = 1'b1;
            valid = 1'b1;
         end
         StBranch: begin
            src_a  = 2'b10;
            aluop  = AluopSub;
            branch = 1'b1;
            valid  = 1'b1;
         end
         StJal: begin
            src_a     = 2'b01;
            src_b     = 2'b10;
            pc_update = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      unique case (i_funct3)
         3'b000:  taken = i_zero;
         3'b001:  taken = ~i_zero;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      imm_src = 2'b00;
      if (i_opcode == OP_SW) begin
         imm_src = 2'b01;
      end else if (i_opcode == OP_BR) begin
         imm_src = 2'b10;
      end else if (i_opcode == OP_JAL) begin
         imm_src = 2'b11;
      end
   end

   // Subtract for funct3 000 only on R-type (opcode bit 5); on I-type
   // funct7b5 is an immediate bit.
   always_comb begin
      alu_ctrl = ALU_ADD;
      unique case (aluop)
         AluopAdd: alu_ctrl = ALU_ADD;
         AluopSub: alu_ctrl = ALU_SUB;
         AluopFunct: begin
            unique case (i_funct3)
               3'b000:  alu_ctrl = (i_opcode[5] & i_funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_ctrl = ALU_SLL;
               3'b010:  alu_ctrl = ALU_SLT;
               3'b011:  alu_ctrl = ALU_SLTU;
               3'b100:  alu_ctrl = ALU_XOR;
               3'b101:  alu_ctrl = i_funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_ctrl = ALU_OR;
               3'b111:  alu_ctrl = ALU_AND;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         default: alu_ctrl = ALU_ADD;
      endcase
   end

   // Reset suppresses every output, including the cycle reset is first seen.
   assign o_pc_en      = ~i_rst & (pc_update | (branch & taken));
   assign o_ir_en      = ~i_rst & ir_en;
   assign o_mem_we     = ~i_rst & mem_we;
   assign o_rf_we      = ~i_rst & rf_we;
   assign o_adr_src    = ~i_rst & adr_src;
   assign o_valid      = ~i_rst & valid;
   assign o_illegal    = ~i_rst & illegal;
   assign o_result_src = i_rst ? 2'b00 : result_src;
   assign o_alu_src_a  = i_rst ? 2'b00 : src_a;
   assign o_alu_src_b  = i_rst ? 2'b00 : src_b;
   assign o_imm_src    = i_rst ? 2'b00 : imm_src;
   assign o_alu_ctrl   = i_rst ? '0 : alu_ctrl;

endmodule

// File: tb/tb_riscv_multi_ctrl.sv
// -----------------------------------------------------------------------------
// tb_riscv_multi_ctrl
// Directed bench for riscv_multi_ctrl. A per-instruction model gives the
// expected output word for each cycle of each instruction class; it is compared
// against the DUT on every falling edge. A few literal checks pin that model.
// -----------------------------------------------------------------------------
module tb_riscv_multi_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;

   logic       pc_en, ir_en, mem_we, rf_we, adr_src, valid, illegal;
   logic [1:0] result_src, src_a, src_b, imm_src;
   logic [3:0] alu_ctrl;

   int errors = 0;
   int checks = 0;
   int step   = 0;

   localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BR = 4, C_JAL = 5, C_ILL = 6;

   riscv_multi_ctrl #(
      .BW_CTRL(4),
      .BW_OP  (7)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_opcode    (opcode),
      .i_funct3    (funct3),
      .i_funct7b5  (funct7b5),
      .i_zero      (zero),
      .o_pc_en     (pc_en),
      .o_ir_en     (ir_en),
      .o_mem_we    (mem_we),
      .o_rf_we     (rf_we),
      .o_adr_src   (adr_src),
      .o_result_src(result_src),
      .o_alu_src_a (src_a),
      .o_alu_src_b (src_b),
      .o_imm_src   (imm_src),
      .o_alu_ctrl  (alu_ctrl),
      .o_valid     (valid),
      .o_illegal   (illegal)
   );

   always #5 clk = ~clk;

   logic [18:0] dut_vec;
   assign dut_vec = {pc_en, ir_en, mem_we, rf_we, adr_src, result_src, src_a, src_b,
                     imm_src, alu_ctrl, valid, illegal};

   function automatic int cls_of(input logic [6:0] op, input logic [2:0] f3);
      case (op)
         7'b0000011: return C_LW;
         7'b0100011: return C_SW;
         7'b0110011: return C_R;
         7'b0010011: return C_I;
         7'b1100011: return (f3 == 3'd0 || f3 == 3'd1) ? C_BR : C_ILL;
         7'b1101111: return C_JAL;
         default:    return C_ILL;
      endcase
   endfunction

   function automatic int cpi_of(input int c);
      case (c)
         C_LW:    return 5;
         C_SW:    return 4;
         C_R:     return 4;
         C_I:     return 4;
         C_BR:    return 3;
         C_JAL:   return 4;
         default: return 2;
      endcase
   endfunction

   function automatic logic [3:0] funct_alu(input logic [6:0] op, input logic [2:0] f3,
                                            input logic f7);
      case (f3)
         3'd0:    return (op[5] && f7) ? 4'd1 : 4'd0;
         3'd1:    return 4'd6;
         3'd2:    return 4'd5;
         3'd3:    return 4'd9;
         3'd4:    return 4'd4;
         3'd5:    return f7 ? 4'd8 : 4'd7;
         3'd6:    return 4'd3;
         default: return 4'd2;
      endcase
   endfunction

   // Expected output word for cycle number s of the instruction on the inputs.
   function automatic logic [18:0] exp_vec(input logic [6:0] op, input logic [2:0] f3,
                                           input logic f7, input logic z, input int s);
      logic pc, ir, mw, rw, adr, v, ill;
      logic [1:0] rs, sa, sb, imm;
      logic [3:0] alu;
      int c;
      c = cls_of(op, f3);
      {pc, ir, mw, rw, adr, v, ill} = '0;
      rs = 2'd0; sa = 2'd0; sb = 2'd0; alu = 4'd0;
      imm = (op == 7'b0100011) ? 2'd1 : (op == 7'b1100011) ? 2'd2 :
            (op == 7'b1101111) ? 2'd3 : 2'd0;
      if (s == 0) begin
         ir = 1'b1; pc = 1'b1; sb = 2'd2; rs = 2'd2;
      end else if (s == 1) begin
         sa = 2'd1; sb = 2'd1; ill = (c == C_ILL);
      end else begin
         case (c)
            C_LW, C_SW: begin
               if (s == 2) begin
                  sa = 2'd2; sb = 2'd1;
               end else if (s == 3 && c == C_LW) begin
                  adr = 1'b1;
               end else if (s == 3) begin
                  adr = 1'b1; mw = 1'b1; v = 1'b1;
               end else begin
                  rs = 2'd1; rw = 1'b1; v = 1'b1;
               end
            end
            C_R, C_I: begin
               if (s == 2) begin
                  sa = 2'd2; sb = (c == C_I) ? 2'd1 : 2'd0; alu = funct_alu(op, f3, f7);
               end else begin
                  rw = 1'b1; v = 1'b1;
               end
            end
            C_BR: begin
               sa = 2'd2; alu = 4'd1; v = 1'b1;
               pc = (f3 == 3'd0) ? z : ~z;
            end
            C_JAL: begin
               if (s == 2) begin
                  sa = 2'd1; sb = 2'd2; pc = 1'b1;
               end else begin
                  rw = 1'b1; v = 1'b1;
               end
            end
            default: ;
         endcase
      end
      return {pc, ir, mw, rw, adr, rs, sa, sb, imm, alu, v, ill};
   endfunction

   // Model position within the current instruction.
   always @(posedge clk) begin
      if (rst) begin
         step <= 0;
      end else if (step >= cpi_of(cls_of(opcode, funct3)) - 1) begin
         step <= 0;
      end else begin
         step <= step + 1;
      end
   end

   always @(negedge clk) begin
      logic [18:0] want;
      want = rst ? 19'd0 : exp_vec(opcode, funct3, funct7b5, zero, step);
      checks = checks + 1;
      if (dut_vec !== want) begin
         errors = errors + 1;
         $display("FAIL cycle_model t=%0t step=%0d got=%b want=%b", $time, step, dut_vec,
                  want);
      end
   end

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got=%b want=%b", name, act, exp);
      end
   endtask

   task automatic do_pin(input int pin);
      case (pin)
         1: begin
            chk("reset_release_ir_en", {3'd0, ir_en}, 4'd1);
            chk("reset_release_pc_en", {3'd0, pc_en}, 4'd1);
            chk("reset_release_src_b", {2'd0, src_b}, 4'd2);
         end
         2: chk("sub_alu_ctrl", alu_ctrl, 4'b0001);
         3: chk("addi_f7_alu_ctrl", alu_ctrl, 4'b0000);
         4: chk("srai_alu_ctrl", alu_ctrl, 4'b1000);
         5: chk("lw_wb_rf_rs_v", {rf_we, result_src, valid}, 4'b1011);
         6: begin
            chk("sw_mw_adr", {2'd0, mem_we, adr_src}, 4'b0011);
            chk("sw_imm_src", {2'd0, imm_src}, 4'b0001);
         end
         7: chk("branch_taken_pc_en", {3'd0, pc_en}, 4'd1);
         8: chk("branch_not_taken_pc_en", {3'd0, pc_en}, 4'd0);
         9: chk("jal_pc_sa_sb", {pc_en, src_a, src_b[1]}, 4'b1011);
         10: chk("illegal_pulse_no_we", {illegal, mem_we, rf_we, 1'b0}, 4'b1000);
         default: ;
      endcase
   endtask

   // Called #1 after a rising edge at the start of a FETCH cycle.
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic z, input int pin_step, input int pin);
      int n;
      opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
      n = cpi_of(cls_of(op, f3));
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == pin_step) do_pin(pin);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset mid-way through an R-type: walk to EXECR, then hold reset 3 cycles.
      opcode = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("reset_strobes_zero", {pc_en, ir_en, mem_we | rf_we, valid | illegal}, 4'd0);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, 0, 1);   // sub, entered from reset
      run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, 2, 2);   // sub
      run_instr(7'b0010011, 3'd0, 1'b1, 1'b0, 2, 3);   // addi, imm bit 10 set
      run_instr(7'b0010011, 3'd5, 1'b1, 1'b0, 2, 4);   // srai
      run_instr(7'b0110011, 3'd5, 1'b0, 1'b0, 0, 0);   // srl
      run_instr(7'b0110011, 3'd3, 1'b0, 1'b1, 0, 0);   // sltu
      run_instr(7'b0010011, 3'd6, 1'b0, 1'b0, 0, 0);   // ori
      run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 4, 5);   // lw
      run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 3, 6);   // sw
      run_instr(7'b1100011, 3'd0, 1'b0, 1'b1, 2, 7);   // beq taken
      run_instr(7'b1100011, 3'd0, 1'b0, 1'b0, 2, 8);   // beq not taken
      run_instr(7'b1100011, 3'd1, 1'b0, 1'b0, 2, 7);   // bne taken
      run_instr(7'b1100011, 3'd1, 1'b0, 1'b1, 2, 8);   // bne not taken
      run_instr(7'b1101111, 3'd0, 1'b0, 1'b0, 2, 9);   // jal
      run_instr(7'b1110011, 3'd0, 1'b0, 1'b0, 1, 10);  // system opcode: illegal
      run_instr(7'b1100011, 3'd4, 1'b0, 1'b0, 1, 10);  // blt: unsupported branch
      run_instr(7'b0110011, 3'd7, 1'b0, 1'b0, 0, 0);   // and
      run_instr(7'b0010011, 3'd2, 1'b0, 1'b0, 0, 0);   // slti

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
